// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch FIFO fed by a one-cycle-latency memory,
// with at most one request outstanding and a flushing redirect.
module prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  output logic                         im_req_o,
  output logic [XLEN-1:0]              im_addr_o,
  input  logic [31:0]                  im_dout_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  output logic                         inst_valid_o,
  output logic [31:0]                  inst_o,
  output logic [XLEN-1:0]              inst_pc_o,
  input  logic                         inst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, flight_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic            pop, push;
  logic [CW:0]     occupancy;
  assign pop       = inst_valid_o & inst_ready_i;
  // A redirect in the return cycle drops the data of the request issued just before it.
  assign push      = inflight_q & !redirect_i;
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign im_req_o  = rst_n_i & !redirect_i & (occupancy < DEPTH_C);
  assign im_addr_o = fetch_pc_q;
  assign fetch_pc_d = redirect_i ? {redirect_pc_i[XLEN-1:2], 2'b00}
                    : im_req_o   ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
  assign count_d   = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q  <= RESET_PC;
      flight_pc_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= im_req_o;
      flight_pc_q <= im_req_o ? fetch_pc_q : flight_pc_q;
      count_q     <= count_d;
      rd_ptr_q    <= redirect_i ? '0 : rd_ptr_q + PW'(pop);
      wr_ptr_q    <= redirect_i ? '0 : wr_ptr_q + PW'(push);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= im_dout_i;
      pc_mem[wr_ptr_q]   <= flight_pc_q;
    end
  end
  assign inst_valid_o = count_q != '0;
  assign inst_o       = inst_mem[rd_ptr_q];
  assign inst_pc_o    = pc_mem[rd_ptr_q];
  assign count_o      = count_q;
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] zero.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-006 im_req_o  output  1  instruction-memory read request this cycle.
REQ-007 im_addr_o  output  XLEN  read address, valid when im_req_o=1.
REQ-008 im_dout_i  input  32  read data, valid exactly one cycle after the accepted request.
REQ-009 redirect_i  input  1  discard all queued/in-flight instructions and refetch from redirect_pc_i.
REQ-010 redirect_pc_i  input  XLEN  new fetch address; bits [1:0] ignored (treated as 0).
REQ-011 inst_valid_o  output  1  queue head holds a valid instruction.
REQ-012 inst_o  output  32  head instruction word.
REQ-013 inst_pc_o  output  XLEN  address the head instruction was fetched from.
REQ-014 inst_ready_i  input  1  consumer accepts head; transfer (pop) when inst_valid_o & inst_ready_i.
REQ-015 count_o  output  $clog2(DEPTH+1)  number of valid queue entries.

Function
REQ-016 Instruction memory is always ready; each request returns data one cycle later; at most one request is in flight.
REQ-017 fetch_pc register holds the next address to request; im_addr_o = fetch_pc.
REQ-018 im_req_o = !redirect_i & (count + inflight - pop < DEPTH), pop being the current-cycle transfer.
REQ-019 On each issued request fetch_pc advances by 4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0).
REQ-020 Returning data, unless killed, is written at the tail with its fetch address at the end of the return cycle.
REQ-021 Request issued in cycle C: data on im_dout_i in C+1, inst_valid_o=1 with that instruction in C+2 at the earliest.
REQ-022 With inst_ready_i held high and no redirect, steady-state throughput is one instruction per cycle for any DEPTH >= 2.
REQ-023 Queue is FIFO; inst_o/inst_pc_o come from registered storage, no combinational path from im_dout_i.
REQ-024 Full (count=DEPTH): no write can occur because REQ-018 blocked the request; push and pop in the same cycle leave count unchanged.
REQ-025 Empty: inst_valid_o=0; inst_o/inst_pc_o are don't-care.
REQ-026 Redirect in cycle R: at end of R count becomes 0, any request issued in R-1 is killed (its data in R is dropped), fetch_pc <= {redirect_pc_i[XLEN-1:2],2'b00}; no request in R.
REQ-027 After redirect in R: request to the new PC in R+1, inst_valid_o=0 in R+1 and R+2, first new instruction valid in R+3.
REQ-028 Redirect and pop in the same cycle: redirect wins, the pop still counts as a transfer for the consumer, the queue is emptied.
REQ-029 Consecutive redirects: the last one determines fetch_pc; no instruction from an earlier target is ever presented.
REQ-030 Read/write pointers wrap modulo DEPTH.

Reset
REQ-031 While rst_n_i=0: fetch_pc=RESET_PC, count_o=0, inst_valid_o=0, in-flight flag cleared, im_req_o=0.
REQ-032 Reset asserted mid-operation discards all queued and in-flight instructions immediately; no stale instruction appears after release.
REQ-033 First request (to RESET_PC) in the first cycle after rst_n_i deasserts.

Verification
REQ-034 Reset release, ready=1, memory returns addr as data -> im_addr_o 0,4,8..., inst_valid_o from cycle 2, inst_pc_o 0,4,8 on consecutive cycles, no bubbles.
REQ-035 ready=0 for 10 cycles, DEPTH=4 -> count_o saturates at 4, im_req_o=0 while full, head stays pc 0; then ready=1 -> pcs 0,4,8,12,16 in order, none lost or duplicated.
REQ-036 Redirect to 32'h0000_0102 while 3 entries queued -> count_o=0 next cycle, im_addr_o=32'h100 in R+1, inst_pc_o=32'h100 valid in R+3, old pcs never appear.
REQ-037 Redirect asserted together with a pop and with data returning -> returned data dropped, count_o=0, next valid pc equals redirect target.
REQ-038 Redirect to 32'hFFFF_FFF8 -> fetched pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-039 rst_n_i pulsed low mid-stream with full queue -> outputs reset asynchronously, after release fetch restarts at RESET_PC with count_o=0.
